// File: rtl/lpc_reg_bank.sv
// LPC register bank plus port-80h POST-code FIFO. Read data is combinational in the strobe cycle; writes land next cycle.
// Strobes are edge-qualified single accesses with no backpressure; a push into a full FIFO drops data and sets a sticky overflow.
module lpc_reg_bank #(
    parameter int          FIFO_DEPTH = 8,
    parameter logic [7:0]  VERSION    = 8'h16,
    parameter logic [7:0]  POST_ADDR  = 8'h80,
    parameter logic [7:0]  CTRL_RST   = 8'h00
) (
    input  logic       i_LPCClk,
    input  logic       i_rst_n,
    input  logic [7:0] i_lpc_addr,
    input  logic [7:0] i_lpc_wdata,
    input  logic       i_lpc_write,
    input  logic       i_lpc_read,
    output logic [7:0] o_lpc_rdata,
    input  logic [7:0] i_board_in,
    output logic [7:0] o_ctrl,
    output logic [7:0] o_post_code,
    output logic       o_post_valid
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;

    localparam logic [7:0] A_VERSION = 8'h00;
    localparam logic [7:0] A_SCRATCH = 8'h01;
    localparam logic [7:0] A_CTRL    = 8'h02;
    localparam logic [7:0] A_STATUS  = 8'h03;
    localparam logic [7:0] A_FDATA   = 8'h04;
    localparam logic [7:0] A_FCMD    = 8'h05;
    localparam logic [7:0] A_BOARD   = 8'h06;

    logic          wr_prev;
    logic          rd_prev;
    logic          wr_acc;
    logic          rd_acc;
    logic [7:0]    scratch;
    logic [7:0]    board_s1;
    logic [7:0]    board_s2;
    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          overflow;
    logic          fifo_empty;
    logic          fifo_full;
    logic          push;
    logic          push_ok;
    logic          pop;
    logic [7:0]    status;
    logic [7:0]    head;

    // Simultaneous rising edges: the write wins and the read's side effect (pop) is dropped.
    assign wr_acc = i_lpc_write & ~wr_prev;
    assign rd_acc = i_lpc_read & ~rd_prev & ~wr_acc;

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == CW'(FIFO_DEPTH));
    assign push       = wr_acc && (i_lpc_addr == POST_ADDR);
    assign push_ok    = push && !fifo_full;
    assign pop        = rd_acc && (i_lpc_addr == A_FDATA) && (i_lpc_addr != POST_ADDR) && !fifo_empty;
    assign head       = fifo_empty ? 8'h00 : fifo_mem[rd_ptr];
    assign status     = {1'b0, overflow, fifo_full, fifo_empty, 4'(count)};

    always_ff @(posedge i_LPCClk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_prev  <= 1'b0;
            rd_prev  <= 1'b0;
            board_s1 <= 8'h00;
            board_s2 <= 8'h00;
        end else begin
            wr_prev  <= i_lpc_write;
            rd_prev  <= i_lpc_read;
            board_s1 <= i_board_in;
            board_s2 <= board_s1;
        end
    end

    always_ff @(posedge i_LPCClk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            scratch <= 8'h00;
            o_ctrl  <= CTRL_RST;
        end else if (wr_acc && (i_lpc_addr != POST_ADDR)) begin
            if (i_lpc_addr == A_SCRATCH) scratch <= i_lpc_wdata;
            if (i_lpc_addr == A_CTRL)    o_ctrl  <= i_lpc_wdata;
        end
    end

    always_ff @(posedge i_LPCClk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_post_code  <= 8'h00;
            o_post_valid <= 1'b0;
        end else if (push) begin
            o_post_code  <= i_lpc_wdata;
            o_post_valid <= 1'b1;
        end
    end

    // Storage needs no reset: count gates every observable read of it.
    always_ff @(posedge i_LPCClk) begin
        if (push_ok) fifo_mem[wr_ptr] <= i_lpc_wdata;
    end

    always_ff @(posedge i_LPCClk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PW'(1);
                count  <= count + CW'(1);
            end else if (push) begin
                overflow <= 1'b1;
            end else if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
                count  <= count - CW'(1);
            end else if (wr_acc && (i_lpc_addr == A_FCMD)) begin
                if (i_lpc_wdata[0]) begin
                    wr_ptr <= '0;
                    rd_ptr <= '0;
                    count  <= '0;
                end
                if (i_lpc_wdata[1]) overflow <= 1'b0;
            end
        end
    end

    always_comb begin
        o_lpc_rdata = 8'hFF;
        if (i_lpc_addr == POST_ADDR) begin
            o_lpc_rdata = o_post_code;
        end else begin
            case (i_lpc_addr)
                A_VERSION: o_lpc_rdata = VERSION;
                A_SCRATCH: o_lpc_rdata = scratch;
                A_CTRL:    o_lpc_rdata = o_ctrl;
                A_STATUS:  o_lpc_rdata = status;
                A_FDATA:   o_lpc_rdata = head;
                A_FCMD:    o_lpc_rdata = 8'h00;
                A_BOARD:   o_lpc_rdata = board_s2;
                default:   o_lpc_rdata = 8'hFF;
            endcase
        end
    end

endmodule

// File: doc/lpc_reg_bank.md
Name: lpc_reg_bank

Overview:
- Register bank and POST-code capture FIFO sitting directly downstream of the LPC slave in the CPLD.
- Consumes the slave's decoded 8-bit address, write data and single-access read/write strobes.
- Returns read data combinationally in the same cycle as the read strobe, because the slave samples read data on that cycle.
- Exposes the version, scratch, control, board-status and port-80h POST-code registers to the host.

Parameters:
- FIFO_DEPTH, 8, POST FIFO entries; power of two, 2..8.
- VERSION, 8'h16, value returned by the VERSION register.
- POST_ADDR, 8'h80, LPC low-byte address of the POST code port.
- CTRL_RST, 8'h00, reset value of the CTRL register.

Ports:
- i_LPCClk  in  1  LPC clock; the only clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_lpc_addr  in  8  access address from the LPC slave.
- i_lpc_wdata  in  8  write data from the LPC slave.
- i_lpc_write  in  1  write strobe.
- i_lpc_read  in  1  read strobe.
- o_lpc_rdata  out  8  read data, combinational from i_lpc_addr and register state.
- i_board_in  in  8  asynchronous board status pins.
- o_ctrl  out  8  CTRL register contents.
- o_post_code  out  8  last POST code written.
- o_post_valid  out  1  high once any POST code has been written since reset.

Behaviour:
- Clock and reset: one clock, i_LPCClk. Reset i_rst_n is asynchronous, active-low.
- Reset values:
  - o_ctrl=CTRL_RST, SCRATCH=0, o_post_code=0, o_post_valid=0.
  - FIFO empty, pointers 0, overflow=0, board sync flops=0.
- Strobe qualification:
  - A write access is the rising edge of i_lpc_write; a read access is the rising edge of i_lpc_read.
  - Each strobe has a one-flop previous-value register. A strobe held high N cycles is one access.
  - Write and read rising in the same cycle: the write is performed, the read side effect is suppressed.
- Register map (all 8-bit):
  - 0x00 VERSION: RO, =VERSION.
  - 0x01 SCRATCH: RW.
  - 0x02 CTRL: RW, drives o_ctrl.
  - 0x03 STATUS: RO.
    - [3:0] fifo count (0..FIFO_DEPTH).
    - [4] empty, [5] full, [6] overflow (sticky), [7] 0.
  - 0x04 FIFO_DATA: RO. Returns the head entry, or 0x00 when empty. A read access pops on the edge that ends the qualifying cycle; pop when empty is ignored with no underflow.
  - 0x05 FIFO_CMD: WO, reads 0x00.
    - bit0=1 flushes the FIFO (pointers and count to 0).
    - bit1=1 clears overflow.
    - Both bits may be set in one write.
  - 0x06 BOARD_IN: RO, i_board_in passed through a 2-flop synchronizer (2-cycle latency).
  - POST_ADDR: write pushes i_lpc_wdata into the FIFO, updates o_post_code the next cycle and sets o_post_valid. Read returns o_post_code with no side effect.
  - Unmapped addresses: read 0xFF, writes ignored. Writes to RO registers are ignored.
- FIFO:
  - Circular buffer, read/write pointers of log2(FIFO_DEPTH) bits wrapping modulo depth, separate count register.
  - Push when full: data dropped, overflow set, pointers and count unchanged; o_post_code is still updated.
  - Flush in the same cycle as a pending push cannot occur, since both are writes and only one write happens per cycle.
- Read data timing: o_lpc_rdata is purely combinational so it is valid in the strobe cycle. Register updates are visible from the next cycle.
- Reset mid-access: all state returns to reset values immediately. The strobe edge flops reset to 0, so a strobe still high when reset releases counts as a new access.

Test Plan:
- Reset, then read 0x00, 0x02, 0x03 -> 0x16, 0x00, 0x10 (empty, count 0); o_post_valid=0.
- Write 0x5A to 0x01, read 0x01 -> 0x5A. Write 0xC3 to 0x02 -> o_ctrl=0xC3 next cycle.
- Write 0x11, 0x22, 0x33 to 0x80 -> o_post_code=0x33, STATUS=0x03. Read 0x04 three times -> 0x11, 0x22, 0x33, then STATUS=0x10. A fourth read returns 0x00 and STATUS stays 0x10.
- Write 9 codes 0x01..0x09 to 0x80 (depth 8) -> STATUS=0x68 (full, overflow, count 8), o_post_code=0x09. Reads drain 0x01..0x08. Write 0x02 to 0x05 -> overflow clears, STATUS=0x10.
- Hold i_lpc_read high 3 cycles at 0x04 with 2 entries -> only one pop, count 1. Write 0x01 to 0x05 -> STATUS=0x10.
- Drive i_board_in=0xA5 -> BOARD_IN reads 0xA5 from the 3rd cycle on. Read 0x7F -> 0xFF. Assert i_rst_n low mid-FIFO-fill -> STATUS=0x10 and o_ctrl=CTRL_RST immediately.
